// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle divider: state encodings,
// handshake levels and bus widths.
package div_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  localparam int RegBus       = 32;
  localparam int DoubleRegBus = 64;

  localparam logic [RegBus-1:0] ZeroWord = '0;

endpackage

// File: rtl/div.sv
// Radix-2 restoring divider beside execute. One quotient bit per cycle;
// signed operands are divided as magnitudes and sign-corrected at the end.
module div
  import div_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);

  localparam logic [CNT_W-1:0] CntDone = CNT_W'(DATA_W);

  div_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2*DATA_W:0]     work_q, work_d;
  logic [DATA_W-1:0]     divisor_q, divisor_d;
  logic                  dvd_neg_q, dvd_neg_d;
  logic                  dvs_neg_q, dvs_neg_d;
  logic                  signed_q, signed_d;
  logic [2*DATA_W-1:0]   result_q, result_d;
  logic                  ready_q, ready_d;

  // Operand magnitudes at acceptance time; unsigned divides pass through.
  logic [DATA_W-1:0] dvd_abs, dvs_abs;
  assign dvd_abs = (signed_div_i && opdata1_i[DATA_W-1]) ? (ZeroWord - opdata1_i) : opdata1_i;
  assign dvs_abs = (signed_div_i && opdata2_i[DATA_W-1]) ? (ZeroWord - opdata2_i) : opdata2_i;

  // Trial subtraction of the divisor from the upper partial remainder;
  // the top bit set means the divisor did not fit.
  logic [DATA_W:0] diff;
  assign diff = work_q[2*DATA_W:DATA_W] - {1'b0, divisor_q};

  // Final sign correction: quotient negative when signs differ,
  // remainder follows the dividend.
  logic [DATA_W-1:0] quot, rem;
  assign quot = (signed_q && (dvd_neg_q ^ dvs_neg_q)) ? (ZeroWord - work_q[DATA_W-1:0])
                                                      : work_q[DATA_W-1:0];
  assign rem  = (signed_q && dvd_neg_q) ? (ZeroWord - work_q[2*DATA_W:DATA_W+1])
                                        : work_q[2*DATA_W:DATA_W+1];

  // Next-state and datapath updates for each FSM state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    dvd_neg_d = dvd_neg_q;
    dvs_neg_d = dvs_neg_q;
    signed_d  = signed_q;
    result_d  = result_q;
    ready_d   = ready_q;
    case (state_q)
      DivFree: begin
        ready_d  = DivResultNotReady;
        result_d = '0;
        if (start_i == DivStart && !annul_i) begin
          state_d   = (opdata2_i == ZeroWord) ? DivByZero : DivOn;
          cnt_d     = '0;
          divisor_d = dvs_abs;
          dvd_neg_d = opdata1_i[DATA_W-1];
          dvs_neg_d = opdata2_i[DATA_W-1];
          signed_d  = signed_div_i;
          work_d    = {ZeroWord, dvd_abs, 1'b0};
        end
      end
      DivByZero: begin
        result_d = '0;
        if (annul_i) begin
          state_d = DivFree;
          ready_d = DivResultNotReady;
        end else begin
          state_d = DivEnd;
          ready_d = DivResultReady;
        end
      end
      DivOn: begin
        if (annul_i) begin
          // Abandon without ever exposing a partial result.
          state_d  = DivFree;
          ready_d  = DivResultNotReady;
          result_d = '0;
        end else if (cnt_q != CntDone) begin
          if (diff[DATA_W]) work_d = {work_q[2*DATA_W-1:0], 1'b0};
          else              work_d = {diff[DATA_W-1:0], work_q[DATA_W-1:0], 1'b1};
          cnt_d = cnt_q + 1'b1;
        end else begin
          state_d  = DivEnd;
          result_d = {rem, quot};
          ready_d  = DivResultReady;
        end
      end
      DivEnd: begin
        // Hold the result until execute drops start.
        if (start_i == DivStop) begin
          state_d  = DivFree;
          ready_d  = DivResultNotReady;
          result_d = '0;
        end
      end
      default: state_d = DivFree;
    endcase
  end

  // State and datapath registers, synchronously cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DivFree;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      dvd_neg_q <= 1'b0;
      dvs_neg_q <= 1'b0;
      signed_q  <= 1'b0;
      result_q  <= '0;
      ready_q   <= DivResultNotReady;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      dvd_neg_q <= dvd_neg_d;
      dvs_neg_q <= dvs_neg_d;
      signed_q  <= signed_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed corner cases plus random divides
// compared against a magnitude/sign arithmetic model.
module tb_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  div #(.DATA_W(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: divide magnitudes with 64-bit arithmetic, then apply signs.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint ma, mb, q, r;
    logic   na, nb;
    logic [63:0] qv, rv;
    if (b == 32'd0) return 64'd0;
    na = sgn && a[31];
    nb = sgn && b[31];
    ma = na ? -longint'($signed(a)) : longint'(a);
    mb = nb ? -longint'($signed(b)) : longint'(b);
    q  = ma / mb;
    r  = ma % mb;
    if (na ^ nb) q = -q;
    if (na) r = -r;
    qv = q;
    rv = r;
    return {rv[31:0], qv[31:0]};
  endfunction

  // One full handshake: start held through completion, then dropped.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b);
    int n;
    int lat;
    logic [63:0] exp;
    exp = ref_div(sgn, a, b);
    lat = (b == 32'd0) ? 2 : 34;
    @(negedge clk);
    signed_div_i = sgn; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
    @(posedge clk); #1;
    n = 1;
    // Operands are don't-care once accepted.
    opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = 1'($urandom);
    while (!ready_o && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'(lat));
    chk({tag, "_res"}, result_o, exp);
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_hold_rdy"}, 64'(ready_o), 64'd1);
    chk({tag, "_hold_res"}, result_o, exp);
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_drop_rdy"}, 64'(ready_o), 64'd0);
    chk({tag, "_drop_res"}, result_o, 64'd0);
  endtask

  initial begin
    int n;
    logic seen;
    logic sg;
    logic [31:0] a, b;

    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", 64'(ready_o), 64'd0);
    chk("rst_res", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases.
    run_div("u100_7", 1'b0, 32'd100, 32'd7);
    chk("u100_7_model", ref_div(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
    run_div("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'h2);
    run_div("s_7_m2", 1'b1, 32'h7, 32'hFFFF_FFFE);
    run_div("zero", 1'b0, 32'd1234, 32'd0);
    run_div("s_zero", 1'b1, 32'h8000_0000, 32'd0);
    run_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_div("u_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);

    // Annul pulsed at E10 with start dropped: nothing may appear.
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1; start_i = 1'b0;
    @(posedge clk); #1;
    chk("annul_rdy", 64'(ready_o), 64'd0);
    chk("annul_res", result_o, 64'd0);
    @(negedge clk);
    annul_i = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready_o || result_o != 64'd0) seen = 1'b1;
    end
    chk("annul_quiet", 64'(seen), 64'd0);
    run_div("after_annul", 1'b0, 32'hFFFF_FFFF, 32'd1);

    // Synchronous reset at E20, start kept high: fresh divide follows.
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd12345678; opdata2_i = 32'd9; start_i = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    signed_div_i = 1'b1; opdata1_i = 32'hFFFF_FC18; opdata2_i = 32'd7;
    @(posedge clk); #1;
    chk("rst_mid_rdy", 64'(ready_o), 64'd0);
    chk("rst_mid_res", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ready_o && n < 100);
    chk("rst_fresh_lat", 64'(n), 64'd34);
    chk("rst_fresh_res", result_o, ref_div(1'b1, 32'hFFFF_FC18, 32'd7));
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);

    // Random divides over a mix of divisor magnitudes and signs.
    for (int i = 0; i < 40; i++) begin
      sg = 1'($urandom);
      a  = $urandom;
      case ($urandom_range(0, 4))
        0:       b = $urandom;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'd0 - $urandom_range(1, 15);
        3:       b = $urandom >> $urandom_range(0, 31);
        default: b = (i % 10 == 0) ? 32'd0 : ($urandom | 32'h1);
      endcase
      run_div($sformatf("rnd%0d", i), sg, a, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
